// File: rtl/fdtd_alu_pkg.sv
// Shared types and constants for the FDTD ALU accumulate/rescale stage.
// Contents: accumulator state enum, default guard width, and the saturation
// bounds helper used by the combinational rescale/saturate block.
package fdtd_alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } acc_state_e;

    localparam int DEFAULT_GUARD = 4;

    // Largest and smallest signed WIDTH-bit values, widened to 128 bits so any
    // rescaled sum up to 128 bits can be compared against them directly.
    function automatic logic signed [127:0] sat_max(input int width);
        return (128'sd1 <<< (width - 1)) - 128'sd1;
    endfunction

    function automatic logic signed [127:0] sat_min(input int width);
        return -(128'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/fdtd_round_sat.sv
// Combinational rescale of an accumulator sum by FRAC bits, then signed saturation to WIDTH.
// Ports: sum_i (ACCW signed sum) -> out_data_o (WIDTH signed), sat_o (result was clamped).
// FDTD_ACC_ROUND_EN defined: round-half-up (bias 2^(FRAC-1)); undefined: truncate toward -inf.
module fdtd_round_sat
    import fdtd_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int ACCW  = 2 * WIDTH + DEFAULT_GUARD
) (
    input  logic [ACCW-1:0]  sum_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             sat_o
);

    // One extra bit so the rounding bias cannot wrap a near-full-scale sum.
    localparam int RW = ACCW + 1;

`ifdef FDTD_ACC_ROUND_EN
    localparam logic [RW-1:0] BIAS = (FRAC > 0) ? (RW'(1) << ((FRAC > 0) ? FRAC - 1 : 0)) : '0;
`else
    localparam logic [RW-1:0] BIAS = '0;
`endif

    localparam logic signed [127:0] MAXV = sat_max(WIDTH);
    localparam logic signed [127:0] MINV = sat_min(WIDTH);

    logic signed [RW-1:0]  sum_x;
    logic signed [RW-1:0]  biased;
    logic signed [RW-1:0]  r;
    logic signed [127:0]   r_wide;

    always_comb begin
        sum_x  = {sum_i[ACCW-1], sum_i};
        biased = sum_x + $signed(BIAS);
        r      = biased >>> FRAC;
        r_wide = {{(128 - RW){r[RW-1]}}, r};

        out_data_o = r[WIDTH-1:0];
        sat_o      = 1'b0;
        if (r_wide > MAXV) begin
            out_data_o = MAXV[WIDTH-1:0];
            sat_o      = 1'b1;
        end else if (r_wide < MINV) begin
            out_data_o = MINV[WIDTH-1:0];
            sat_o      = 1'b1;
        end
    end

endmodule

// File: rtl/fdtd_acc_round_sat.sv
// Accumulates a group of signed 2*WIDTH products, rescales by FRAC and saturates to WIDTH.
// Ports: CLK/RST (async active-high), in_valid/in_ready/in_last/in_p beats, out_valid/out_ready/out_data/out_sat result.
// Result registered one edge after the last beat; in_ready low while a result is held. Macro: FDTD_ACC_ROUND_EN.
module fdtd_acc_round_sat
    import fdtd_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int GUARD = DEFAULT_GUARD
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic [2*WIDTH-1:0] in_p,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_sat
);

    localparam int ACCW = 2 * WIDTH + GUARD;

    acc_state_e        state_q;
    logic [ACCW-1:0]   acc_q;
    logic [ACCW-1:0]   sum_d;
    logic              out_valid_q;
    logic [WIDTH-1:0]  out_data_q;
    logic              out_sat_q;
    logic [WIDTH-1:0]  rs_data;
    logic              rs_sat;
    logic              beat_acc;

    // Gated by RST so upstream never sees a handshake while the stage is held in reset.
    assign in_ready = !RST && (state_q != ST_OUT);
    assign beat_acc = in_valid && in_ready;

    // Overflow past the guard bits wraps; group length is bounded upstream.
    assign sum_d = acc_q + {{GUARD{in_p[2*WIDTH-1]}}, in_p};

    fdtd_round_sat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .ACCW  (ACCW)
    ) u_round_sat (
        .sum_i      (sum_d),
        .out_data_o (rs_data),
        .sat_o      (rs_sat)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACC: begin
                    if (beat_acc) begin
                        if (in_last) begin
                            acc_q       <= '0;
                            out_data_q  <= rs_data;
                            out_sat_q   <= rs_sat;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_OUT;
                        end else begin
                            acc_q   <= sum_d;
                            state_q <= ST_ACC;
                        end
                    end
                end
                ST_OUT: begin
                    // Result stays on out_data/out_sat until the next group completes.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    acc_q       <= '0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_fdtd_acc_round_sat.sv
// Directed bench for fdtd_acc_round_sat at WIDTH=32, FRAC=16.
// Expected values are hand-computed; rounding expectations follow FDTD_ACC_ROUND_EN.
// Inputs change #1 after the rising edge; outputs are sampled at that point too.
module tb_fdtd_acc_round_sat;

    logic        CLK;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [63:0] in_p;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sat;

    int checks;
    int failures;

    fdtd_acc_round_sat #(
        .WIDTH (32),
        .FRAC  (16),
        .GUARD (4)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_p      (in_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Present one beat for exactly one rising edge.
    task automatic drive_beat(input logic [63:0] p, input logic last);
        in_valid = 1'b1;
        in_p     = p;
        in_last  = last;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_p     = '0;
    endtask

    // Single-cycle out_ready pulse to release a held result.
    task automatic pop_result();
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
    endtask

    // Run a one-beat group and compare the result.
    task automatic run_single(input string name, input logic [63:0] p,
                              input logic [31:0] exp_data, input logic exp_sat);
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL %s_ready_before got=%b exp=1", name, in_ready);
            failures++;
        end
        drive_beat(p, 1'b1);
        checks++;
        if (out_valid !== 1'b1) begin
            $display("FAIL %s_valid got=%b exp=1", name, out_valid);
            failures++;
        end
        checks++;
        if (out_data !== exp_data) begin
            $display("FAIL %s_data got=%h exp=%h", name, out_data, exp_data);
            failures++;
        end
        checks++;
        if (out_sat !== exp_sat) begin
            $display("FAIL %s_sat got=%b exp=%b", name, out_sat, exp_sat);
            failures++;
        end
        pop_result();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL %s_release got valid=%b ready=%b exp valid=0 ready=1",
                     name, out_valid, in_ready);
            failures++;
        end
    endtask

    task automatic test_reset();
        RST       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_p      = '0;
        out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sat !== 1'b0 || in_ready !== 1'b0) begin
            $display("FAIL reset_state got valid=%b data=%h sat=%b ready=%b exp 0/0/0/0",
                     out_valid, out_data, out_sat, in_ready);
            failures++;
        end
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_release_ready got=%b exp=1", in_ready);
            failures++;
        end
    endtask

    task automatic test_single();
        run_single("single", 64'h0000_0003_0000_0000, 32'h0003_0000, 1'b0);
    endtask

    task automatic test_three_beat();
        drive_beat(64'h0000_0001_0000_0000, 1'b0);
        drive_beat(64'h0000_0001_0000_0000, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL three_mid got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
            failures++;
        end
        drive_beat(64'h0000_0001_0000_0000, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0003_0000) begin
            $display("FAIL three_result got valid=%b data=%h exp valid=1 data=00030000",
                     out_valid, out_data);
            failures++;
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK);
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                $display("FAIL three_ready_in_out cycle=%0d got=%b exp=0", i, in_ready);
                failures++;
            end
        end
        pop_result();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL three_release got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid);
            failures++;
        end
    endtask

    task automatic test_rounding();
`ifdef FDTD_ACC_ROUND_EN
        run_single("round_pos_half", 64'h0000_0000_0000_8000, 32'h0000_0001, 1'b0);
        run_single("round_neg_half", 64'hFFFF_FFFF_FFFF_8000, 32'h0000_0000, 1'b0);
`else
        run_single("trunc_pos_half", 64'h0000_0000_0000_8000, 32'h0000_0000, 1'b0);
        run_single("trunc_neg_half", 64'hFFFF_FFFF_FFFF_8000, 32'hFFFF_FFFF, 1'b0);
`endif
    endtask

    task automatic test_saturation();
        run_single("sat_pos", 64'h7FFF_FFFF_0000_0000, 32'h7FFF_FFFF, 1'b1);
        run_single("sat_neg", 64'h8000_0001_0000_0000, 32'h8000_0000, 1'b1);
    endtask

    task automatic test_backpressure();
        drive_beat(64'h0000_0002_0000_0000, 1'b1);
        // Offer a competing last beat the whole time the result is held.
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_p     = 64'h0000_0009_0000_0000;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h0002_0000 || in_ready !== 1'b0) begin
                $display("FAIL bp_hold cycle=%0d got valid=%b data=%h ready=%b exp valid=1 data=00020000 ready=0",
                         i, out_valid, out_data, in_ready);
                failures++;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_p     = '0;
        pop_result();
        // The refused beat must not have leaked into the accumulator.
        run_single("bp_after", 64'h0000_0001_0000_0000, 32'h0001_0000, 1'b0);
    endtask

    task automatic test_reset_midgroup();
        // Leave a saturated result visible so a cleared output is observable.
        drive_beat(64'h8000_0001_0000_0000, 1'b1);
        pop_result();
        drive_beat(64'h0000_0005_0000_0000, 1'b0);
        drive_beat(64'h0000_0005_0000_0000, 1'b0);
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sat !== 1'b0 || in_ready !== 1'b0) begin
            $display("FAIL rst_mid got valid=%b data=%h sat=%b ready=%b exp 0/0/0/0",
                     out_valid, out_data, out_sat, in_ready);
            failures++;
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        run_single("rst_after", 64'h0000_0007_0000_0000, 32'h0007_0000, 1'b0);
    endtask

    task automatic test_back_to_back();
        drive_beat(64'h0000_0004_0000_0000, 1'b1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_last   = 1'b1;
        in_p      = 64'h0000_0006_0000_0000;
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
        // Handshake edge is a bubble: beat is still waiting, nothing new is valid.
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL b2b_bubble got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
            failures++;
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_p     = '0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0006_0000) begin
            $display("FAIL b2b_second got valid=%b data=%h exp valid=1 data=00060000", out_valid, out_data);
            failures++;
        end
        pop_result();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_three_beat();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_reset_midgroup();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
